// File: rtl/muldiv.sv
// Iterative 32-bit multiply/divide unit owning the HI/LO pair.
// One operand-capture edge, 32 shift-add / shift-subtract edges, one sign-fix edge.
module muldiv (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Mthi,
    input  logic        Mtlo,
    input  logic [31:0] Wd,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    // state | meaning
    // IDLE  | waiting for Start; Mthi/Mtlo writes allowed
    // RUN   | 32 iterations on working registers
    // FIX   | sign correction, HI/LO write, Done pulse
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic        op_div;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;
    logic [31:0] hi_w;
    logic [31:0] lo_w;
    logic [31:0] opb;

    logic        a_neg, b_neg;
    logic [31:0] a_abs, b_abs;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_sub;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = RUN;
            RUN:     if (cnt == 5'd31) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        a_neg     = Op[0] & A[31];
        b_neg     = Op[0] & B[31];
        a_abs     = a_neg ? -A : A;
        b_abs     = b_neg ? -B : B;
        mul_sum   = {1'b0, hi_w} + (lo_w[0] ? {1'b0, opb} : 33'd0);
        div_shift = {hi_w, lo_w[31]};
        div_ge    = div_shift >= {1'b0, opb};
        // Remainder stays below the divisor, so the low 32 bits hold the full difference.
        div_sub   = div_shift[31:0] - opb;
        prod_fix  = neg_q ? -{hi_w, lo_w} : {hi_w, lo_w};
        quo_fix   = div_zero ? 32'hFFFF_FFFF : (neg_q ? -lo_w : lo_w);
        rem_fix   = neg_r ? -hi_w : hi_w;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt      <= '0;
            op_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi_w     <= '0;
            lo_w     <= '0;
            opb      <= '0;
        end else begin
            case (state)
                IDLE: if (Start) begin
                    cnt      <= '0;
                    op_div   <= Op[1];
                    neg_q    <= Op[0] & (A[31] ^ B[31]);
                    neg_r    <= (Op == 2'b11) & A[31];
                    // Divide by zero: quotient forced later; remainder naturally ends as |A|.
                    div_zero <= Op[1] & (B == 32'd0);
                    hi_w     <= '0;
                    lo_w     <= a_abs;
                    opb      <= b_abs;
                end
                RUN: begin
                    cnt <= cnt + 5'd1;
                    if (!op_div) begin
                        hi_w <= mul_sum[32:1];
                        lo_w <= {mul_sum[0], lo_w[31:1]};
                    end else if (div_ge) begin
                        hi_w <= div_sub;
                        lo_w <= {lo_w[30:0], 1'b1};
                    end else begin
                        hi_w <= div_shift[31:0];
                        lo_w <= {lo_w[30:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Hi   <= '0;
            Lo   <= '0;
            Done <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (state == FIX) begin
                Done <= 1'b1;
                if (op_div) begin
                    Hi <= rem_fix;
                    Lo <= quo_fix;
                end else begin
                    Hi <= prod_fix[63:32];
                    Lo <= prod_fix[31:0];
                end
            end else if (state == IDLE && !Start) begin
                if (Mthi) Hi <= Wd;
                if (Mtlo) Lo <= Wd;
            end
        end
    end

    assign Busy = (state != IDLE);

endmodule
